krnl_acc_axi_ctrl_master: RTL and testbench

AXI4-Lite control master that drives the accelerator's control-register slave from the other end of the bus. It accepts one job command and writes the ten configuration registers, then writes ap_start. It polls CTRL until ap_done, writes ap_continue, and reports completion. It sits between an on-chip scheduler or testbench sequencer and the kernel's s_axi_control port.

---
 rtl/krnl_acc_axi_ctrl_master.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_krnl_acc_axi_ctrl_master.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/krnl_acc_axi_ctrl_master.sv
// AXI4-Lite control master: programs the kernel config registers,
// starts the kernel, polls CTRL for ap_done and issues ap_continue.
//
// Ports:
//   ACLK, ARESETn        clock, async active-low reset
//   cmd_*                job request (valid/ready) and config values
//   busy                 high whenever a job is in progress
//   job_done, job_err    one-cycle completion pulse, error flag
//   M_AW*/M_W*/M_B*      AXI-Lite write channels to the kernel slave
//   M_AR*/M_R*           AXI-Lite read channels to the kernel slave

module krnl_acc_axi_ctrl_master #(
  parameter int ADDR_WIDTH    = 12,
  parameter int POLL_INTERVAL = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [31:0]           cmd_ci,
  input  logic [31:0]           cmd_co,
  input  logic [31:0]           cmd_ifm_size,
  input  logic [31:0]           cmd_wgt_size,
  input  logic [63:0]           cmd_ifm_addr,
  input  logic [63:0]           cmd_wgt_addr,
  input  logic [63:0]           cmd_ofm_addr,

  output logic                  busy,
  output logic                  job_done,
  output logic                  job_err,

  output logic [ADDR_WIDTH-1:0] M_AWADDR,
  output logic                  M_AWVALID,
  input  logic                  M_AWREADY,
  output logic [31:0]           M_WDATA,
  output logic [3:0]            M_WSTRB,
  output logic                  M_WVALID,
  input  logic                  M_WREADY,
  input  logic [1:0]            M_BRESP,
  input  logic                  M_BVALID,
  output logic                  M_BREADY,
  output logic [ADDR_WIDTH-1:0] M_ARADDR,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  input  logic [31:0]           M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RVALID,
  output logic                  M_RREADY
);

  localparam int CW =
    (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(POLL_INTERVAL - 1);

  localparam logic [3:0] IDX_START = 4'd10;
  localparam logic [3:0] IDX_CONT  = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WRESP,
    S_POLL,
    S_RADDR,
    S_RDATA,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          awv_q, awv_d;
  logic          wv_q, wv_d;

  logic [31:0]   ci_q, ci_d;
  logic [31:0]   co_q, co_d;
  logic [31:0]   isz_q, isz_d;
  logic [31:0]   wsz_q, wsz_d;
  logic [63:0]   ifm_q, ifm_d;
  logic [63:0]   wgt_q, wgt_d;
  logic [63:0]   ofm_q, ofm_d;

  logic [11:0]   tbl_addr;
  logic [31:0]   tbl_data;

  logic          unused_rdata;
  assign unused_rdata = ^{M_RDATA[31:2], M_RDATA[0]};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      awv_q   <= 1'b0;
      wv_q    <= 1'b0;
      ci_q    <= '0;
      co_q    <= '0;
      isz_q   <= '0;
      wsz_q   <= '0;
      ifm_q   <= '0;
      wgt_q   <= '0;
      ofm_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      awv_q   <= awv_d;
      wv_q    <= wv_d;
      ci_q    <= ci_d;
      co_q    <= co_d;
      isz_q   <= isz_d;
      wsz_q   <= wsz_d;
      ifm_q   <= ifm_d;
      wgt_q   <= wgt_d;
      ofm_q   <= ofm_d;
    end
  end

  // Register table; index only moves in WRESP/RDATA, so the
  // selected address/data are stable for the whole WR phase.
  always_comb begin
    tbl_addr = 12'h000;
    tbl_data = 32'h0;
    unique case (idx_q)
      4'd0: begin
        tbl_addr = 12'h010;
        tbl_data = ci_q;
      end
      4'd1: begin
        tbl_addr = 12'h014;
        tbl_data = co_q;
      end
      4'd2: begin
        tbl_addr = 12'h018;
        tbl_data = isz_q;
      end
      4'd3: begin
        tbl_addr = 12'h01C;
        tbl_data = wsz_q;
      end
      4'd4: begin
        tbl_addr = 12'h020;
        tbl_data = ifm_q[31:0];
      end
      4'd5: begin
        tbl_addr = 12'h024;
        tbl_data = ifm_q[63:32];
      end
      4'd6: begin
        tbl_addr = 12'h028;
        tbl_data = wgt_q[31:0];
      end
      4'd7: begin
        tbl_addr = 12'h02C;
        tbl_data = wgt_q[63:32];
      end
      4'd8: begin
        tbl_addr = 12'h030;
        tbl_data = ofm_q[31:0];
      end
      4'd9: begin
        tbl_addr = 12'h034;
        tbl_data = ofm_q[63:32];
      end
      4'd10: tbl_data = 32'h0000_0001;
      4'd11: tbl_data = 32'h0000_0010;
      default: begin
        tbl_addr = 12'h000;
        tbl_data = 32'h0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    awv_d   = awv_q;
    wv_d    = wv_q;
    ci_d    = ci_q;
    co_d    = co_q;
    isz_d   = isz_q;
    wsz_d   = wsz_q;
    ifm_d   = ifm_q;
    wgt_d   = wgt_q;
    ofm_d   = ofm_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ci_d    = cmd_ci;
          co_d    = cmd_co;
          isz_d   = cmd_ifm_size;
          wsz_d   = cmd_wgt_size;
          ifm_d   = cmd_ifm_addr;
          wgt_d   = cmd_wgt_addr;
          ofm_d   = cmd_ofm_addr;
          err_d   = 1'b0;
          idx_d   = '0;
          awv_d   = 1'b1;
          wv_d    = 1'b1;
          state_d = S_WR;
        end
      end

      // AW and W retire independently, in any order.
      S_WR: begin
        if (awv_q && M_AWREADY) awv_d = 1'b0;
        if (wv_q && M_WREADY)   wv_d  = 1'b0;
        if (!awv_d && !wv_d)    state_d = S_WRESP;
      end

      S_WRESP: begin
        if (M_BVALID) begin
          err_d = err_q | (M_BRESP != 2'b00);
          if (idx_q == IDX_CONT) begin
            state_d = S_DONE;
          end else if (idx_q == IDX_START) begin
            cnt_d   = '0;
            state_d = S_POLL;
          end else begin
            idx_d   = idx_q + 4'd1;
            awv_d   = 1'b1;
            wv_d    = 1'b1;
            state_d = S_WR;
          end
        end
      end

      S_POLL: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_RADDR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RADDR: begin
        if (M_ARREADY) state_d = S_RDATA;
      end

      // RDATA[1] is ap_done in the kernel CTRL register.
      S_RDATA: begin
        if (M_RVALID) begin
          err_d = err_q | (M_RRESP != 2'b00);
          if (M_RDATA[1]) begin
            idx_d   = IDX_CONT;
            awv_d   = 1'b1;
            wv_d    = 1'b1;
            state_d = S_WR;
          end else begin
            cnt_d   = '0;
            state_d = S_POLL;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // Held low while reset is asserted, even though the state is IDLE.
  assign cmd_ready = (state_q == S_IDLE) & ARESETn;
  assign busy      = (state_q != S_IDLE);
  assign job_done  = (state_q == S_DONE);
  assign job_err   = (state_q == S_DONE) & err_q;

  assign M_AWVALID = awv_q;
  assign M_AWADDR  = awv_q ? ADDR_WIDTH'(tbl_addr) : '0;
  assign M_WVALID  = wv_q;
  assign M_WDATA   = wv_q ? tbl_data : '0;
  assign M_WSTRB   = 4'hF;
  assign M_BREADY  = (state_q == S_WRESP);
  assign M_ARVALID = (state_q == S_RADDR);
  assign M_ARADDR  = '0;
  assign M_RREADY  = (state_q == S_RDATA);

endmodule

// File: tb/tb_krnl_acc_axi_ctrl_master.sv
// Bench for krnl_acc_axi_ctrl_master: AXI-Lite slave model,
// write scoreboard and job-completion scoreboard.

module tb_krnl_acc_axi_ctrl_master;

  localparam int AW = 12;
  localparam int PI = 16;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [31:0]   cmd_ci, cmd_co, cmd_ifm_size, cmd_wgt_size;
  logic [63:0]   cmd_ifm_addr, cmd_wgt_addr, cmd_ofm_addr;
  logic          busy, job_done, job_err;
  logic [AW-1:0] M_AWADDR;
  logic          M_AWVALID, M_AWREADY;
  logic [31:0]   M_WDATA;
  logic [3:0]    M_WSTRB;
  logic          M_WVALID, M_WREADY;
  logic [1:0]    M_BRESP;
  logic          M_BVALID, M_BREADY;
  logic [AW-1:0] M_ARADDR;
  logic          M_ARVALID, M_ARREADY;
  logic [31:0]   M_RDATA;
  logic [1:0]    M_RRESP;
  logic          M_RVALID, M_RREADY;

  krnl_acc_axi_ctrl_master #(
    .ADDR_WIDTH(AW),
    .POLL_INTERVAL(PI)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ci(cmd_ci), .cmd_co(cmd_co),
    .cmd_ifm_size(cmd_ifm_size),
    .cmd_wgt_size(cmd_wgt_size),
    .cmd_ifm_addr(cmd_ifm_addr),
    .cmd_wgt_addr(cmd_wgt_addr),
    .cmd_ofm_addr(cmd_ofm_addr),
    .busy(busy), .job_done(job_done), .job_err(job_err),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID),
    .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
    .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID),
    .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID),
    .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge ACLK) cyc++;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;
  typedef struct {
    logic err;
    int   reads;
  } done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  int    done_cnt = 0;

  // slave knobs
  int aw_delay = 0;
  int w_delay = 0;
  int err_idx = -1;
  int done_on = 1;
  int wr_idx = 0;
  int rd_idx = 0;
  bit hs_aw, hs_w, hs_b, hs_ar, hs_r;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [11:0] a,
                         input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_wr.push_back(e);
  endtask

  task automatic push_done(input logic err, input int reads);
    done_t e;
    e.err = err;
    e.reads = reads;
    exp_done.push_back(e);
  endtask

  task automatic push_job(input logic [31:0] ci, co, isz, wsz,
                          input logic [63:0] ia, wa, oa,
                          input logic err, input int reads);
    push_wr(12'h010, ci);
    push_wr(12'h014, co);
    push_wr(12'h018, isz);
    push_wr(12'h01C, wsz);
    push_wr(12'h020, ia[31:0]);
    push_wr(12'h024, ia[63:32]);
    push_wr(12'h028, wa[31:0]);
    push_wr(12'h02C, wa[63:32]);
    push_wr(12'h030, oa[31:0]);
    push_wr(12'h034, oa[63:32]);
    push_wr(12'h000, 32'h1);
    push_wr(12'h000, 32'h10);
    push_done(err, reads);
  endtask

  task automatic set_cmd(input logic [31:0] ci, co, isz, wsz,
                         input logic [63:0] ia, wa, oa);
    cmd_ci = ci;
    cmd_co = co;
    cmd_ifm_size = isz;
    cmd_wgt_size = wsz;
    cmd_ifm_addr = ia;
    cmd_wgt_addr = wa;
    cmd_ofm_addr = oa;
  endtask

  task automatic start_job(input logic [31:0] ci, co, isz, wsz,
                           input logic [63:0] ia, wa, oa);
    int n;
    @(negedge ACLK);
    set_cmd(ci, co, isz, wsz, ia, wa, oa);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 4000) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 4000) check("cmd_accept_timeout", 1, 0);
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_jobs(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 5000) begin
      @(negedge ACLK);
      n++;
    end
    @(negedge ACLK);
    check("job_done_count", done_cnt, target);
  endtask

  // AXI-Lite slave model: drives readies/responses at negedge.
  initial begin
    int aw_cnt, w_cnt;
    bit aw_got, w_got;
    M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = 0;
    M_ARREADY = 0; M_RVALID = 0; M_RDATA = 0; M_RRESP = 0;
    aw_cnt = 0; w_cnt = 0; aw_got = 0; w_got = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0;
        M_BRESP = 0; M_ARREADY = 0; M_RVALID = 0;
        M_RDATA = 0;
        aw_cnt = 0; w_cnt = 0; aw_got = 0; w_got = 0;
        wr_idx = 0; rd_idx = 0;
        hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
        continue;
      end
      if (job_done) begin
        wr_idx = 0;
        rd_idx = 0;
      end
      if (hs_aw) begin aw_got = 1; M_AWREADY = 0; end
      if (hs_w) begin w_got = 1; M_WREADY = 0; end
      if (hs_b) begin
        M_BVALID = 0; M_BRESP = 0;
        aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
        wr_idx++;
      end
      if (hs_ar) begin
        M_ARREADY = 0;
        rd_idx++;
        M_RVALID = 1;
        M_RDATA = (rd_idx >= done_on) ? 32'h2 : 32'h0;
      end
      if (hs_r) begin M_RVALID = 0; M_RDATA = 0; end
      if (M_AWVALID && !aw_got && !M_AWREADY) begin
        if (aw_cnt >= aw_delay) M_AWREADY = 1;
        else aw_cnt++;
      end
      if (M_WVALID && !w_got && !M_WREADY) begin
        if (w_cnt >= w_delay) M_WREADY = 1;
        else w_cnt++;
      end
      if (aw_got && w_got && !M_BVALID) begin
        M_BVALID = 1;
        M_BRESP = (wr_idx == err_idx) ? 2'b10 : 2'b00;
      end
      if (M_ARVALID && !M_ARREADY && !M_RVALID) M_ARREADY = 1;
      hs_aw = M_AWVALID && M_AWREADY;
      hs_w  = M_WVALID && M_WREADY;
      hs_b  = M_BVALID && M_BREADY;
      hs_ar = M_ARVALID && M_ARREADY;
      hs_r  = M_RVALID && M_RREADY;
    end
  end

  // Monitor: pairs observed AW/W beats, pops expected writes,
  // checks VALID timing and job completion.
  initial begin
    logic [11:0] obs_a[$];
    logic [31:0] obs_d[$];
    logic [11:0] oa, pa;
    logic [31:0] od, pd;
    bit pav, pwv, phaw, phw;
    int b_cnt, rd_cnt, last_ar;
    wr_t e;
    done_t de;
    pav = 0; pwv = 0; phaw = 0; phw = 0;
    pa = 0; pd = 0; b_cnt = 0; rd_cnt = 0; last_ar = 0;
    forever begin
      @(negedge ACLK);
      #1;
      if (!ARESETn) begin
        obs_a.delete(); obs_d.delete();
        pav = 0; pwv = 0; phaw = 0; phw = 0;
        b_cnt = 0; rd_cnt = 0;
        continue;
      end
      if (pav) begin
        if (phaw) check("awvalid_drop", M_AWVALID, 0);
        else begin
          check("awvalid_hold", M_AWVALID, 1);
          check("awaddr_stable", M_AWADDR, pa);
        end
      end
      if (pwv) begin
        if (phw) check("wvalid_drop", M_WVALID, 0);
        else begin
          check("wvalid_hold", M_WVALID, 1);
          check("wdata_stable", M_WDATA, pd);
        end
      end
      if (hs_aw) obs_a.push_back(M_AWADDR);
      if (hs_w) begin
        obs_d.push_back(M_WDATA);
        check("wstrb", M_WSTRB, 4'hF);
      end
      while (obs_a.size() > 0 && obs_d.size() > 0) begin
        oa = obs_a.pop_front();
        od = obs_d.pop_front();
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", oa, e.a);
          check("wr_data", od, e.d);
          if (e.a == 12'h000 && e.d == 32'h10 &&
              exp_done.size() > 0)
            check("continue_after_reads",
                  rd_cnt, exp_done[0].reads);
        end
      end
      if (hs_b) b_cnt++;
      if (hs_ar) begin
        check("araddr", M_ARADDR, 0);
        if (rd_cnt > 0)
          check("poll_gap_ok", (cyc - last_ar) >= PI, 1);
        last_ar = cyc;
        rd_cnt++;
      end
      if (job_done) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          de = exp_done.pop_front();
          check("job_err", job_err, de.err);
          check("b_per_job", b_cnt, 12);
          check("reads_per_job", rd_cnt, de.reads);
        end
        b_cnt = 0;
        rd_cnt = 0;
        done_cnt++;
      end
      pav = M_AWVALID; pwv = M_WVALID;
      phaw = hs_aw; phw = hs_w;
      pa = M_AWADDR; pd = M_WDATA;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    cmd_valid = 0;
    set_cmd(0, 0, 0, 0, 0, 0, 0);

    // reset state
    #12;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_awvalid", M_AWVALID, 0);
    check("rst_wvalid", M_WVALID, 0);
    check("rst_arvalid", M_ARVALID, 0);
    check("rst_awaddr", M_AWADDR, 0);
    check("rst_wdata", M_WDATA, 0);
    check("rst_job_done", job_done, 0);
    @(negedge ACLK);
    ARESETn = 1;
    @(negedge ACLK);
    check("post_rst_cmd_ready", cmd_ready, 1);

    // 1: zero-wait slave, done on first poll
    push_wr(12'h010, 32'h3);
    push_wr(12'h014, 32'h8);
    push_wr(12'h018, 32'h100);
    push_wr(12'h01C, 32'h48);
    push_wr(12'h020, 32'h2000);
    push_wr(12'h024, 32'h1);
    push_wr(12'h028, 32'h4000);
    push_wr(12'h02C, 32'h2);
    push_wr(12'h030, 32'h8000);
    push_wr(12'h034, 32'h3);
    push_wr(12'h000, 32'h1);
    push_wr(12'h000, 32'h10);
    push_done(0, 1);
    start_job(32'h3, 32'h8, 32'h100, 32'h48,
              64'h1_0000_2000, 64'h2_0000_4000,
              64'h3_0000_8000);
    wait_jobs(1);

    // 2: AW before W, then W before AW
    aw_delay = 0; w_delay = 3;
    push_job(32'h11, 32'h22, 32'h33, 32'h44,
             64'hA_1111_0000, 64'hB_2222_0000,
             64'hC_3333_0000, 0, 1);
    start_job(32'h11, 32'h22, 32'h33, 32'h44,
              64'hA_1111_0000, 64'hB_2222_0000,
              64'hC_3333_0000);
    wait_jobs(2);
    aw_delay = 3; w_delay = 0;
    push_job(32'h5, 32'h6, 32'h7, 32'h9,
             64'h0_DEAD_BEEF, 64'hF_0000_0001,
             64'h1_2345_6789, 0, 1);
    start_job(32'h5, 32'h6, 32'h7, 32'h9,
              64'h0_DEAD_BEEF, 64'hF_0000_0001,
              64'h1_2345_6789);
    wait_jobs(3);
    aw_delay = 0; w_delay = 0;

    // 3: ap_done on third poll
    done_on = 3;
    push_job(32'h1, 32'h2, 32'h3, 32'h4,
             64'h10, 64'h20, 64'h30, 0, 3);
    start_job(32'h1, 32'h2, 32'h3, 32'h4,
              64'h10, 64'h20, 64'h30);
    wait_jobs(4);
    done_on = 1;

    // 4: SLVERR on write index 4, then a clean job
    err_idx = 4;
    push_job(32'h7, 32'h7, 32'h7, 32'h7,
             64'h7, 64'h7, 64'h7, 1, 1);
    start_job(32'h7, 32'h7, 32'h7, 32'h7,
              64'h7, 64'h7, 64'h7);
    wait_jobs(5);
    err_idx = -1;
    push_job(32'h8, 32'h8, 32'h8, 32'h8,
             64'h8, 64'h8, 64'h8, 0, 1);
    start_job(32'h8, 32'h8, 32'h8, 32'h8,
              64'h8, 64'h8, 64'h8);
    wait_jobs(6);

    // 5: cmd_valid held high with new fields during a job
    push_job(32'hA1, 32'hA2, 32'hA3, 32'hA4,
             64'hA5, 64'hA6, 64'hA7, 0, 1);
    push_job(32'hB1, 32'hB2, 32'hB3, 32'hB4,
             64'hB5, 64'hB6, 64'hB7, 0, 1);
    base = done_cnt;
    @(negedge ACLK);
    set_cmd(32'hA1, 32'hA2, 32'hA3, 32'hA4,
            64'hA5, 64'hA6, 64'hA7);
    cmd_valid = 1;
    check("hold_ready_idle", cmd_ready, 1);
    @(negedge ACLK);
    set_cmd(32'hB1, 32'hB2, 32'hB3, 32'hB4,
            64'hB5, 64'hB6, 64'hB7);
    check("hold_ready_busy", cmd_ready, 0);
    check("hold_busy", busy, 1);
    repeat (20) @(negedge ACLK);
    check("hold_ready_mid", cmd_ready, 0);
    n = 0;
    while (!cmd_ready && n < 4000) begin
      @(negedge ACLK);
      n++;
    end
    check("second_after_first_done", done_cnt, base + 1);
    @(negedge ACLK);
    cmd_valid = 0;
    wait_jobs(base + 2);

    // 6: reset while AWVALID is up at index 6
    aw_delay = 4; w_delay = 4;
    push_job(32'hC1, 32'hC2, 32'hC3, 32'hC4,
             64'hC5, 64'hC6, 64'hC7, 0, 1);
    start_job(32'hC1, 32'hC2, 32'hC3, 32'hC4,
              64'hC5, 64'hC6, 64'hC7);
    n = 0;
    do begin
      @(negedge ACLK);
      #2;
      n++;
    end while (!(wr_idx == 6 && M_AWVALID) && n < 2000);
    check("reached_idx6", M_AWVALID, 1);
    ARESETn = 0;
    #1;
    check("arst_awvalid", M_AWVALID, 0);
    check("arst_wvalid", M_WVALID, 0);
    check("arst_arvalid", M_ARVALID, 0);
    check("arst_bready", M_BREADY, 0);
    check("arst_busy", busy, 0);
    exp_wr.delete();
    exp_done.delete();
    repeat (2) @(negedge ACLK);
    #2;
    ARESETn = 1;
    @(negedge ACLK);
    check("rel_cmd_ready", cmd_ready, 1);
    check("rel_busy", busy, 0);
    aw_delay = 0; w_delay = 0;
    base = done_cnt;
    push_job(32'hD1, 32'hD2, 32'hD3, 32'hD4,
             64'hD5, 64'hD6, 64'hD7, 0, 1);
    start_job(32'hD1, 32'hD2, 32'hD3, 32'hD4,
              64'hD5, 64'hD6, 64'hD7);
    wait_jobs(base + 1);
    check("exp_wr_drained", exp_wr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
